fetch_unit: RTL and testbench

//  Instruction fetch stage. Owns the architectural PC and issues word reads to instruction memory.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM states and alignment helpers.
package cpu_pkg;

    localparam int XLEN = 32;

    // Low address bits that must be zero for a legal instruction address
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        REQ   = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    // True when the two low bits of a target address break word alignment
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, issues one word read at a
// time (no prefetch), presents the fetched instruction downstream and accepts PC
// redirects. Responses belonging to an abandoned path are drained and dropped.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN         = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] program_counter,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            load_new_program_counter,
    input  logic [XLEN-1:0] new_program_counter,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fetch_fault_addr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] prog_pc_q, prog_pc_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            kill_q, kill_d;
    logic            fault_q, fault_d;
    // Holds off the first request until one clock edge after reset release
    logic            run_q;

    logic            redirect;
    logic            bad_target;
    logic [XLEN-1:0] pc_plus4;

    // Only a clean 1 on the shared strobe counts; once faulted, redirects are ignored
    assign redirect   = (load_new_program_counter == 1'b1) && (state_q != FAULT);
    assign bad_target = is_misaligned(new_program_counter[1:0]);
    assign pc_plus4   = pc_q + XLEN'(4);

    assign mem_req_addr     = req_addr_q;
    assign instruction      = instr_q;
    assign program_counter  = prog_pc_q;
    assign fetch_fault      = fault_q;
    assign fetch_fault_addr = fault_addr_q;

    // Next-state and handshake outputs of the fetch FSM
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        prog_pc_d     = prog_pc_q;
        kill_d        = kill_q;
        fault_d       = fault_q;
        fault_addr_d  = fault_addr_q;
        mem_req_valid = 1'b0;
        instr_valid   = 1'b0;

        case (state_q)
            REQ: begin
                mem_req_valid = run_q;
                if (redirect) begin
                    pc_d = new_program_counter;
                end
                if (run_q && mem_req_ready) begin
                    // An accepted request on a dead path must still be drained
                    state_d = (kill_q || redirect) ? DRAIN : WAIT;
                end else if (redirect) begin
                    // Request keeps its address until accepted; remember it is stale
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = new_program_counter;
                    if (mem_rsp_valid) begin
                        // Response lands in the redirect cycle: drop it, refetch at target
                        req_addr_d = new_program_counter;
                        state_d    = REQ;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_rsp_valid) begin
                    instr_d   = mem_rsp_data;
                    prog_pc_d = req_addr_q;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (redirect) begin
                    // Redirect wins over sequential advance even if consumed this cycle
                    pc_d       = new_program_counter;
                    req_addr_d = new_program_counter;
                    state_d    = REQ;
                end else if (instr_ready) begin
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d = new_program_counter;
                end
                if (mem_rsp_valid) begin
                    req_addr_d = redirect ? new_program_counter : pc_q;
                    kill_d     = 1'b0;
                    state_d    = REQ;
                end
            end
            FAULT: begin
                // Terminal until reset; any late response is simply absorbed
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // A misaligned redirect target overrides every other transition
        if (redirect && bad_target) begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = new_program_counter;
            kill_d       = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_VECTOR;
            req_addr_q   <= RESET_VECTOR;
            instr_q      <= '0;
            prog_pc_q    <= RESET_VECTOR;
            fault_addr_q <= '0;
            kill_q       <= 1'b0;
            fault_q      <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            instr_q      <= instr_d;
            prog_pc_q    <= prog_pc_d;
            fault_addr_q <= fault_addr_d;
            kill_q       <= kill_d;
            fault_q      <= fault_d;
            run_q        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model answers accepted requests,
// a program-order reference model predicts which PC is presented next, and a
// monitor compares every presented instruction against those predictions.
`timescale 1ns/1ps
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int             W  = 32;
    localparam logic [W-1:0]   RV = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [W-1:0] mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [W-1:0] mem_rsp_data = '0;
    logic [W-1:0] instruction;
    logic [W-1:0] program_counter;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic         load_new_program_counter = 1'b0;
    logic [W-1:0] new_program_counter = '0;
    logic         fetch_fault;
    logic [W-1:0] fetch_fault_addr;

    fetch_unit #(.XLEN(W), .RESET_VECTOR(RV)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .mem_req_valid            (mem_req_valid),
        .mem_req_ready            (mem_req_ready),
        .mem_req_addr             (mem_req_addr),
        .mem_rsp_valid            (mem_rsp_valid),
        .mem_rsp_data             (mem_rsp_data),
        .instruction              (instruction),
        .program_counter          (program_counter),
        .instr_valid              (instr_valid),
        .instr_ready              (instr_ready),
        .load_new_program_counter (load_new_program_counter),
        .new_program_counter      (new_program_counter),
        .fetch_fault              (fetch_fault),
        .fetch_fault_addr         (fetch_fault_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } rsp_t;

    logic [W-1:0] exp_q[$];      // next PC the DUT must present
    rsp_t         pend[$];       // memory responses owed, in order
    int           cyc = 0;
    int           last_due = 0;
    bit           faulted = 1'b0;
    logic [W-1:0] fault_tgt = '0;
    logic [W-1:0] model_pc = RV;
    bit           override_en = 1'b0;
    logic [W-1:0] override_data = '0;
    logic [W-1:0] last_acc_addr = '0;
    bit           hold_req = 1'b0;
    logic [W-1:0] hold_addr = '0;
    int           prev_valid_cyc = -1;
    int           gap = 0;
    bit           gap_ok = 1'b0;

    // Contents of instruction memory
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (a == RV) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_note(input string name, input logic [W-1:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed %h (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops one expectation per new presentation, checks holds for stability
    bit           prev_v = 1'b0;
    logic [W-1:0] prev_i = '0;
    logic [W-1:0] prev_p = '0;
    int           idle = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            idle   = 0;
        end else begin
            if (instr_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        fail_note("unexpected_instr", program_counter);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        check("present_pc", program_counter, e);
                        check("present_instr", instruction, mem_word(e));
                    end
                end else begin
                    check("hold_pc_stable", program_counter, prev_p);
                    check("hold_instr_stable", instruction, prev_i);
                end
                prev_i = instruction;
                prev_p = program_counter;
                idle   = 0;
            end else begin
                idle++;
                if (idle > 200 && !faulted) begin
                    fail_note("watchdog_no_instr", 32'(idle));
                    idle = 0;
                end
            end
            prev_v = instr_valid;
        end
    end

    // One clock of stimulus: sample Moore outputs, drive inputs, update models
    task automatic step(input bit rdy, input bit irdy, input bit rd,
                        input logic [W-1:0] tgt, input int lat);
        bit acc;
        bit hs;
        int due;
        cyc++;
        acc = mem_req_valid && rdy;
        hs  = instr_valid && irdy;

        if (hold_req && mem_req_valid)
            check("req_addr_stable", mem_req_addr, hold_addr);
        if (faulted) begin
            check("fault_flag", 32'(fetch_fault), 32'd1);
            check("fault_addr", fetch_fault_addr, fault_tgt);
            check("fault_no_req", 32'(mem_req_valid), 32'd0);
            check("fault_no_instr", 32'(instr_valid), 32'd0);
        end

        gap_ok = 1'b0;
        if (instr_valid) begin
            if (prev_valid_cyc >= 0) begin
                gap    = cyc - prev_valid_cyc;
                gap_ok = 1'b1;
            end
            prev_valid_cyc = cyc;
        end

        mem_req_ready            = rdy;
        instr_ready              = irdy;
        load_new_program_counter = rd;
        new_program_counter      = tgt;

        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end

        if (acc) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due      = due;
            last_acc_addr = mem_req_addr;
            pend.push_back('{data: (override_en ? override_data : mem_word(mem_req_addr)), due: due});
            override_en = 1'b0;
        end
        hold_req  = mem_req_valid && !rdy;
        hold_addr = mem_req_addr;

        if (!faulted) begin
            if (rd) begin
                exp_q.delete();
                if (tgt[1:0] != 2'b00) begin
                    faulted   = 1'b1;
                    fault_tgt = tgt;
                end else begin
                    model_pc = tgt;
                    exp_q.push_back(tgt);
                end
            end else if (hs) begin
                model_pc = model_pc + 32'd4;
                exp_q.push_back(model_pc);
            end
        end

        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles_low);
        rst_n                    = 1'b0;
        mem_req_ready            = 1'b0;
        instr_ready              = 1'b0;
        load_new_program_counter = 1'b0;
        mem_rsp_valid            = 1'b0;
        hold_req                 = 1'b0;
        #1;
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_pc", program_counter, RV);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_fault_addr", fetch_fault_addr, 32'd0);
        repeat (cycles_low) @(negedge clk);
        #1;
        rst_n          = 1'b1;
        faulted        = 1'b0;
        model_pc       = RV;
        prev_valid_cyc = -1;
        exp_q.delete();
        exp_q.push_back(RV);
        check("rel_req_valid_low", 32'(mem_req_valid), 32'd0);
    endtask

    // Deliver any responses left over from before a reset while no request is accepted
    task automatic drain_stray();
        for (int i = 0; i < 20 && pend.size() != 0; i++) step(1'b0, 1'b0, 1'b0, '0, 1);
        step(1'b0, 1'b0, 1'b0, '0, 1);
    endtask

    // Advance (consuming instructions, not accepting requests) until a request is offered
    task automatic goto_req();
        for (int i = 0; i < 30 && !mem_req_valid; i++) step(1'b0, 1'b1, 1'b0, '0, 1);
        if (!mem_req_valid) fail_note("goto_req_timeout", 32'(mem_req_valid));
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        #1;

        // Reset release, zero-wait memory, first instruction
        do_reset(2);
        step(1'b0, 1'b0, 1'b0, '0, 1);
        check("t1_req_valid_up", 32'(mem_req_valid), 32'd1);
        check("t1_req_addr", mem_req_addr, RV);
        step(1'b1, 1'b0, 1'b0, '0, 1);
        step(1'b0, 1'b0, 1'b0, '0, 1);
        check("t1_instr_valid", 32'(instr_valid), 32'd1);

        // Straight-line fetch: one instruction every third cycle
        prev_valid_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1);
            if (gap_ok) check("t2_gap", 32'(gap), 32'd3);
        end
        for (int i = 0; i < 6 && !instr_valid; i++) step(1'b1, 1'b0, 1'b0, '0, 1);
        check("t2_hold_entry", 32'(instr_valid), 32'd1);
        repeat (5) step(1'b0, 1'b0, 1'b0, '0, 1);
        check("t2_still_valid", 32'(instr_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, '0, 1);

        // Redirect while waiting; the old response must be dropped
        goto_req();
        override_en   = 1'b1;
        override_data = 32'hDEAD_BEEF;
        step(1'b1, 1'b0, 1'b0, '0, 3);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1);
        goto_req();
        check("t3_req_addr", mem_req_addr, 32'h100);
        step(1'b1, 1'b0, 1'b0, '0, 1);
        check("t3_acc_addr", last_acc_addr, 32'h100);

        // Redirect in HOLD together with instr_ready
        step(1'b0, 1'b0, 1'b0, '0, 1);
        check("t4_in_hold", 32'(instr_valid), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h200, 1);
        check("t4_req_valid", 32'(mem_req_valid), 32'd1);
        check("t4_req_addr", mem_req_addr, 32'h200);
        // Redirect while the request is not yet accepted
        step(1'b0, 1'b0, 1'b1, 32'h300, 1);
        step(1'b0, 1'b0, 1'b0, '0, 1);
        step(1'b0, 1'b0, 1'b0, '0, 1);
        step(1'b1, 1'b0, 1'b0, '0, 2);
        check("t4_stale_acc_addr", last_acc_addr, 32'h200);
        goto_req();
        check("t4_redirect_addr", mem_req_addr, 32'h300);

        // Misaligned redirect target with a response still outstanding
        step(1'b1, 1'b0, 1'b0, '0, 2);
        step(1'b0, 1'b0, 1'b1, 32'h102, 1);
        for (int i = 0; i < 8; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h40, 1);
        do_reset(1);
        drain_stray();

        // Reset in the middle of a transaction, then a stray response
        goto_req();
        step(1'b1, 1'b0, 1'b0, '0, 4);
        step(1'b0, 1'b0, 1'b0, '0, 1);
        do_reset(2);
        drain_stray();
        check("t6_req_addr", mem_req_addr, RV);
        step(1'b1, 1'b0, 1'b0, '0, 1);
        check("t6_acc_addr", last_acc_addr, RV);

        // PC wrap at the top of the address space
        goto_req();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid && program_counter == 32'hFFFF_FFFC) begin
                step(1'b0, 1'b1, 1'b0, '0, 1);
                break;
            end
            step(1'b1, 1'b0, 1'b0, '0, 1);
        end
        check("t6_wrap_req_valid", 32'(mem_req_valid), 32'd1);
        check("t6_wrap_addr", mem_req_addr, 32'h0);

        // Randomized traffic with aligned redirects
        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] t;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 24) == 0), t, $urandom_range(1, 4));
        end
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
